// File: rtl/game_pkg.sv
// Shared constants and the level-to-period mapping for the crossing game.
// The period helper is pure combinational arithmetic on elaboration-time constants plus the level.
package game_pkg;

  localparam int LANE_WIDTH = 20;
  localparam int X_W        = 5;
  localparam int LEVEL_W    = 7;
  localparam int PER_W      = 24;

  localparam int DIR_RIGHT  = 1;
  localparam int DIR_LEFT   = 0;

  // Level 0 behaves as level 1; any underflow or sub-floor result clamps to min_p.
  function automatic logic [63:0] level_to_period(
    input logic [63:0] level,
    input logic [63:0] base,
    input logic [63:0] step,
    input logic [63:0] min_p
  );
    logic [63:0] eff;
    logic [63:0] dec;
    eff = (level == 64'd0) ? 64'd1 : level;
    dec = (eff - 64'd1) * step;
    if ((dec > base) || ((base - dec) < min_p)) begin
      return min_p;
    end
    return base - dec;
  endfunction

endpackage

// File: rtl/lane_step_timer.sv
// Step-rate timer: period_q follows i_Level with 1 cycle latency; o_Tick is combinational from cnt/period.
// Pausing (i_Enable = 0) freezes the count so the interval resumes where it left off.
module lane_step_timer #(
  parameter int LEVEL_W     = game_pkg::LEVEL_W,
  parameter int PER_W       = game_pkg::PER_W,
  parameter int BASE_PERIOD = 1250000,
  parameter int PERIOD_STEP = 50000,
  parameter int MIN_PERIOD  = 250000
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Enable,
  input  logic [LEVEL_W-1:0] i_Level,
  output logic               o_Tick
);
  import game_pkg::*;

  if (MIN_PERIOD < 1) begin : g_bad_min
    $error("lane_step_timer: MIN_PERIOD must be >= 1");
  end
  if (longint'(BASE_PERIOD) >= (longint'(1) << PER_W)) begin : g_bad_base
    $error("lane_step_timer: BASE_PERIOD does not fit in PER_W bits");
  end

  localparam logic [PER_W-1:0] RST_PERIOD =
    PER_W'(level_to_period(64'd1, 64'(BASE_PERIOD), 64'(PERIOD_STEP), 64'(MIN_PERIOD)));

  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign period_d = PER_W'(level_to_period(64'(i_Level), 64'(BASE_PERIOD),
                                           64'(PERIOD_STEP), 64'(MIN_PERIOD)));

  // >= rather than == so a period that shrinks below the running count wraps at once.
  assign tick = i_Enable && (cnt_q >= (period_q - PER_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (i_Enable) begin
      cnt_d = cnt_q + PER_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      period_q <= RST_PERIOD;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_Tick = tick;

endmodule

// File: rtl/car_lane_ctrl.sv
// Lane of NUM_CARS cars moving in lock-step with wrap; o_Step pulses with each position update.
// o_Hit is registered (1 cycle) from the current positions vs the frog; not gated by i_Enable.
module car_lane_ctrl #(
  parameter int LANE_WIDTH  = game_pkg::LANE_WIDTH,
  parameter int X_W         = game_pkg::X_W,
  parameter int NUM_CARS    = 3,
  parameter int CAR_INIT_X  = 0,
  parameter int CAR_SPACING = 7,
  parameter int DIRECTION   = 1,
  parameter int LEVEL_W     = game_pkg::LEVEL_W,
  parameter int PER_W       = game_pkg::PER_W,
  parameter int BASE_PERIOD = 1250000,
  parameter int PERIOD_STEP = 50000,
  parameter int MIN_PERIOD  = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Enable,
  input  logic [LEVEL_W-1:0]      i_Level,
  input  logic [X_W-1:0]          i_Frog_X,
  input  logic                    i_Frog_In_Lane,
  output logic [NUM_CARS*X_W-1:0] o_Cars_X,
  output logic                    o_Step,
  output logic                    o_Hit
);
  import game_pkg::*;

  if (longint'(LANE_WIDTH) > (longint'(1) << X_W)) begin : g_bad_lane
    $error("car_lane_ctrl: LANE_WIDTH does not fit in X_W bits");
  end
  if (NUM_CARS < 1) begin : g_bad_cars
    $error("car_lane_ctrl: NUM_CARS must be >= 1");
  end

  localparam logic [X_W-1:0] X_LAST = X_W'(LANE_WIDTH - 1);

  logic [X_W-1:0] car_q [NUM_CARS];
  logic [X_W-1:0] car_d [NUM_CARS];
  logic           step_q;
  logic           hit_q, hit_d;
  logic           any_match;
  logic           tick;

  lane_step_timer #(
    .LEVEL_W     (LEVEL_W),
    .PER_W       (PER_W),
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_STEP (PERIOD_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_timer (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Enable (i_Enable),
    .i_Level  (i_Level),
    .o_Tick   (tick)
  );

  always_comb begin
    for (int k = 0; k < NUM_CARS; k++) begin
      car_d[k] = car_q[k];
      if (tick) begin
        if (DIRECTION == DIR_RIGHT) begin
          car_d[k] = (car_q[k] == X_LAST) ? '0 : car_q[k] + X_W'(1);
        end else begin
          car_d[k] = (car_q[k] == '0) ? X_LAST : car_q[k] - X_W'(1);
        end
      end
    end
  end

  // Cars never leave 0..LANE_WIDTH-1, so an off-lane frog column cannot match; the range test makes that explicit.
  always_comb begin
    any_match = 1'b0;
    for (int k = 0; k < NUM_CARS; k++) begin
      if (car_q[k] == i_Frog_X) begin
        any_match = 1'b1;
      end
    end
    hit_d = i_Frog_In_Lane && any_match && (int'(i_Frog_X) < LANE_WIDTH);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int k = 0; k < NUM_CARS; k++) begin
        car_q[k] <= X_W'((CAR_INIT_X + k * CAR_SPACING) % LANE_WIDTH);
      end
      step_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CARS; k++) begin
        car_q[k] <= car_d[k];
      end
      step_q <= tick;
      hit_q  <= hit_d;
    end
  end

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_pack
    assign o_Cars_X[g*X_W +: X_W] = car_q[g];
  end

  assign o_Step = step_q;
  assign o_Hit  = hit_q;

endmodule

// File: tb/tb_car_lane_ctrl.sv
// Directed bench for car_lane_ctrl: a right-moving and a left-moving lane share all inputs.
// Short periods (BASE 10, STEP 2, MIN 4) keep every interval hand-countable.
module tb_car_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [6:0]  lvl;
  logic [4:0]  fx;
  logic        fin;
  logic [14:0] cars_r, cars_l;
  logic        step_r, step_l, hit_r, hit_l;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  car_lane_ctrl #(
    .LANE_WIDTH(20), .X_W(5), .NUM_CARS(3), .CAR_INIT_X(0), .CAR_SPACING(7),
    .DIRECTION(1), .LEVEL_W(7), .PER_W(24),
    .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(4)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Level(lvl),
    .i_Frog_X(fx), .i_Frog_In_Lane(fin),
    .o_Cars_X(cars_r), .o_Step(step_r), .o_Hit(hit_r)
  );

  car_lane_ctrl #(
    .LANE_WIDTH(20), .X_W(5), .NUM_CARS(3), .CAR_INIT_X(0), .CAR_SPACING(7),
    .DIRECTION(0), .LEVEL_W(7), .PER_W(24),
    .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(4)
  ) dut_l (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Level(lvl),
    .i_Frog_X(fx), .i_Frog_In_Lane(fin),
    .o_Cars_X(cars_l), .o_Step(step_l), .o_Hit(hit_l)
  );

  function automatic logic [14:0] pk(input int c0, input int c1, input int c2);
    return {5'(c2), 5'(c1), 5'(c0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until the right lane's o_Step is seen high, capped at 200.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!step_r && n < 200);
  endtask

  int          n;
  logic [14:0] snap;
  logic        seen_step, seen_move;

  initial begin
    rst = 1'b1; en = 1'b0; lvl = 7'd1; fx = 5'd0; fin = 1'b0;
    cyc(3);
    check("rst_cars",   32'(cars_r), 32'(pk(0, 7, 14)));
    check("rst_cars_l", 32'(cars_l), 32'(pk(0, 7, 14)));
    check("rst_step",   32'(step_r), 32'd0);
    check("rst_hit",    32'(hit_r),  32'd0);
    rst = 1'b0;

    fx = 5'd7; fin = 1'b1; cyc(1);
    check("hit_car1", 32'(hit_r), 32'd1);
    fin = 1'b0; cyc(1);
    check("hit_out_of_lane", 32'(hit_r), 32'd0);
    fx = 5'd25; fin = 1'b1; cyc(1);
    check("hit_x_off_lane", 32'(hit_r), 32'd0);
    fx = 5'd14; cyc(1);
    check("hit_car2", 32'(hit_r), 32'd1);
    fx = 5'd3; cyc(1);
    check("hit_miss", 32'(hit_r), 32'd0);
    fin = 1'b0; fx = 5'd0;

    en = 1'b1;
    wait_step(n);
    check("lvl1_first_interval", 32'(n), 32'd10);
    check("step1_cars",   32'(cars_r), 32'(pk(1, 8, 15)));
    check("step1_cars_l", 32'(cars_l), 32'(pk(19, 6, 13)));
    check("step1_l_pulse", 32'(step_l), 32'd1);
    cyc(1);
    check("step_one_cycle", 32'(step_r), 32'd0);
    wait_step(n);
    check("step2_interval", 32'(n), 32'd9);
    for (int s = 3; s <= 5; s++) begin
      wait_step(n);
      check("lvl1_interval", 32'(n), 32'd10);
    end
    check("step5_cars", 32'(cars_r), 32'(pk(5, 12, 19)));
    wait_step(n);
    check("step6_wrap", 32'(cars_r), 32'(pk(6, 13, 0)));

    lvl = 7'd3;
    wait_step(n); check("lvl3_a", 32'(n), 32'd6);
    wait_step(n); check("lvl3_b", 32'(n), 32'd6);
    lvl = 7'd10;
    wait_step(n); check("lvl10_floor_a", 32'(n), 32'd4);
    wait_step(n); check("lvl10_floor_b", 32'(n), 32'd4);
    lvl = 7'd0;
    wait_step(n); check("lvl0_as_1", 32'(n), 32'd10);
    lvl = 7'd1;
    wait_step(n); check("lvl1_again", 32'(n), 32'd10);

    // Count to 8, then shrink the period to 4 (below cnt): wrap must follow promptly.
    cyc(8);
    lvl = 7'd5;
    wait_step(n); check("shrink_midcount", 32'(n), 32'd2);
    wait_step(n); check("lvl5_interval", 32'(n), 32'd4);
    lvl = 7'd1;
    wait_step(n); check("lvl1_restore", 32'(n), 32'd10);

    cyc(5);
    en = 1'b0;
    snap = cars_r;
    seen_step = 1'b0; seen_move = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (step_r) seen_step = 1'b1;
      if (cars_r !== snap) seen_move = 1'b1;
    end
    check("pause_no_step", 32'(seen_step), 32'd0);
    check("pause_no_move", 32'(seen_move), 32'd0);
    en = 1'b1;
    wait_step(n); check("resume_remaining", 32'(n), 32'd5);

    // Reset lands on the edge that would otherwise step.
    cyc(9);
    rst = 1'b1; cyc(1);
    check("midrst_cars",   32'(cars_r), 32'(pk(0, 7, 14)));
    check("midrst_cars_l", 32'(cars_l), 32'(pk(0, 7, 14)));
    check("midrst_step",   32'(step_r), 32'd0);
    rst = 1'b0;
    wait_step(n); check("post_rst_interval", 32'(n), 32'd10);
    check("post_rst_cars", 32'(cars_r), 32'(pk(1, 8, 15)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/car_lane_ctrl.md
Name: car_lane_ctrl

Overview:
- Multi-car lane controller for the crossing game.
- Moves NUM_CARS cars in lock-step along one lane row. The step rate is derived arithmetically from the game level, clamped to a floor, and can be paused.
- Outputs all car positions as a packed bus for the display/renderer.
- Reports a registered collision flag against the frog position, feeding the game-state FSM.

Parameters:
- LANE_WIDTH, 20, cells per lane; valid x range 0..LANE_WIDTH-1
- X_W, 5, position width; LANE_WIDTH <= 2**X_W
- NUM_CARS, 3, cars in lane, >= 1
- CAR_INIT_X, 0, reset x of car 0
- CAR_SPACING, 7, reset gap between consecutive cars
- DIRECTION, 1, 1 = increasing x, 0 = decreasing x
- LEVEL_W, 7, level input width
- PER_W, 24, period counter width
- BASE_PERIOD, 1250000, clocks per step at level 1
- PERIOD_STEP, 50000, period reduction per level above 1
- MIN_PERIOD, 250000, period floor, >= 1

Ports:
- i_Clk, in, 1, system clock
- i_Reset, in, 1, synchronous, active-high reset
- i_Enable, in, 1, 1 = cars move; 0 = paused
- i_Level, in, LEVEL_W, current game level
- i_Frog_X, in, X_W, frog column
- i_Frog_In_Lane, in, 1, frog is on this lane's row
- o_Cars_X, out, NUM_CARS*X_W, car k at [k*X_W +: X_W]
- o_Step, out, 1, one-cycle pulse coincident with a position update
- o_Hit, out, 1, registered collision flag

Behaviour:
- **Reset.** i_Reset has priority over all other inputs in the cycle it is sampled.
  - Car k = (CAR_INIT_X + k*CAR_SPACING) mod LANE_WIDTH.
  - cnt = 0, period_q = clamp(BASE_PERIOD), o_Step = 0, o_Hit = 0.
- **Level mapping.**
  - eff_level = 1 when i_Level == 0, otherwise i_Level.
  - raw = BASE_PERIOD - (eff_level-1)*PERIOD_STEP, computed at PER_W+LEVEL_W bits.
  - On underflow, or raw < MIN_PERIOD, period = MIN_PERIOD.
  - Registered into period_q every cycle, giving 1 cycle latency from an i_Level change.
- **Timer** (i_Enable = 1):
  - If cnt >= period_q-1: cnt <= 0 and a step occurs. Otherwise cnt <= cnt+1.
  - The >= compare means a mid-count level increase that shrinks the period below cnt causes a step on the next cycle (no missed wrap).
- **Pause** (i_Enable = 0): cnt holds, no step, positions hold. On resume, counting continues from the held cnt.
- **Step.** All cars update on the same edge.
  - DIRECTION = 1: x == LANE_WIDTH-1 -> 0, otherwise x+1.
  - DIRECTION = 0: x == 0 -> LANE_WIDTH-1, otherwise x-1.
  - o_Step is registered high for exactly that one cycle, aligned with the new o_Cars_X values.
- **o_Cars_X** is driven directly from the position registers, with no additional output stage.
- **Hit.**
  - o_Hit <= i_Frog_In_Lane && (any car_x == i_Frog_X), evaluated on the current registered positions.
  - 1-cycle latency; level output, not sticky; not gated by i_Enable.
  - i_Frog_X >= LANE_WIDTH never hits.
  - Overlapping cars (possible if CAR_SPACING*NUM_CARS wraps) are legal and move independently.
- **Reset mid-operation.** Positions return to their reset values on the next edge. No step pulse is emitted that cycle.
- **Elaboration checks.** Fail elaboration if LANE_WIDTH > 2**X_W, NUM_CARS < 1, MIN_PERIOD < 1, or BASE_PERIOD >= 2**PER_W.

Decomposition:
- Package game_pkg holds:
  - LANE_WIDTH, X_W, LEVEL_W, PER_W
  - DIR_RIGHT = 1, DIR_LEFT = 0
  - function level_to_period (eff_level, subtract, clamp)
- Sub-module lane_step_timer (i_Clk, i_Reset, i_Enable, i_Level -> o_Tick) owns period_q and cnt.
- car_lane_ctrl owns the position array, wrap logic and hit compare.

Test Plan:
All scenarios use BASE_PERIOD = 10, PERIOD_STEP = 2, MIN_PERIOD = 4, LANE_WIDTH = 20, NUM_CARS = 3, CAR_SPACING = 7, CAR_INIT_X = 0.
1. **Reset.** Assert i_Reset 3 cycles, then release -> o_Cars_X cars = {0,7,14}, o_Step = 0, o_Hit = 0.
2. **Stepping and wrap.** Level 1, enable held high -> o_Step every 10 cycles. After step 1, cars = {1,8,15}. After step 5, car2 = 19. After step 6, car2 = 0 and cars = {6,13,0}.
3. **Level mapping.**
   - Level 3 -> steps every 6 cycles.
   - Level 10 -> raw underflows -> every 4 cycles.
   - Level 0 -> every 10 cycles.
   - Switch from level 1 to level 5 when cnt = 8 -> step on the cycle after period_q updates.
4. **DIRECTION = 0.** Car0 at 0 -> step -> 19; car1 7 -> 6.
5. **Pause.** Pause at cnt = 5 for 50 cycles -> no o_Step and positions constant. Re-enable -> next step after exactly 5 more cycles.
6. **Hit and reset.**
   - Frog_X = 7, In_Lane = 1 after reset -> o_Hit = 1 one cycle later.
   - Drop In_Lane -> o_Hit = 0 next cycle.
   - Frog_X = 25 -> o_Hit = 0.
   - Pulse i_Reset mid-run -> cars = {0,7,14} next cycle, o_Step = 0.
